// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter
//   Two-port round-robin arbiter in front of a single-cycle boot ROM.
//   A port is granted combinationally in the cycle it requests. In-range
//   grants strobe the ROM; the response returns on the granted port exactly
//   one cycle later. Out-of-range grants never touch the ROM and respond
//   with err=1 and rdata=0.
//
// Parameters
//   ROM_BYTES   byte size of the ROM window starting at address 0
//
// Ports
//   clk_i                    clock, rising edge
//   rst                      asynchronous active-high reset
//   p{0,1}_req_i/_addr_i     per-port read request and byte address
//   p{0,1}_gnt_o             per-port grant (combinational)
//   p{0,1}_rvalid_o          per-port response valid (registered, 1 cycle)
//   p{0,1}_rdata_o/_err_o    response data / out-of-range flag
//   rom_req_o/_addr_o        ROM strobe and address (address 0 when idle)
//   rom_rdata_i              ROM data, valid 1 cycle after rom_req_o
//   p{0,1}_cnt_o             saturating grant counters, present only when
//                            BOOTROM_ARB_CNT_EN is defined
module bootrom_arbiter #(
  parameter int unsigned ROM_BYTES = 8192
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        p0_req_i,
  input  logic [63:0] p0_addr_i,
  input  logic        p1_req_i,
  input  logic [63:0] p1_addr_i,
  output logic        p0_gnt_o,
  output logic        p1_gnt_o,
  output logic        p0_rvalid_o,
  output logic        p1_rvalid_o,
  output logic [63:0] p0_rdata_o,
  output logic [63:0] p1_rdata_o,
  output logic        p0_err_o,
  output logic        p1_err_o,
`ifdef BOOTROM_ARB_CNT_EN
  output logic [31:0] p0_cnt_o,
  output logic [31:0] p1_cnt_o,
`endif
  output logic        rom_req_o,
  output logic [63:0] rom_addr_o,
  input  logic [63:0] rom_rdata_i
);

  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic vld;
    logic port;
    logic err;
  } rsp_t;

  logic                            prio_q, prio_d;
  rsp_t                            rsp_q, rsp_d;
  logic [NUM_PORTS-1:0]            req, gnt, rvalid, err;
  logic [NUM_PORTS-1:0][63:0]      rdata;
  logic                            gport;
  logic [63:0]                     gaddr;
  logic                            in_rng;

  // Requests are masked while in reset so nothing is granted or strobed.
  assign req = rst ? '0 : {p1_req_i, p0_req_i};

  // prio_q names the port that wins a collision; a lone requester always wins.
  assign gnt[0] = req[0] & (~req[1] | ~prio_q);
  assign gnt[1] = req[1] & (~req[0] |  prio_q);

  assign gport  = gnt[1];
  assign gaddr  = gnt[1] ? p1_addr_i : p0_addr_i;
  assign in_rng = gaddr < 64'(ROM_BYTES);

  assign rom_req_o  = (|gnt) & in_rng;
  assign rom_addr_o = rom_req_o ? gaddr : '0;

  always_comb begin
    prio_d = prio_q;
    rsp_d  = '0;
    if (|gnt) begin
      prio_d     = ~gport;
      rsp_d.vld  = 1'b1;
      rsp_d.port = gport;
      rsp_d.err  = ~in_rng;
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
      rsp_q  <= '0;
    end else begin
      prio_q <= prio_d;
      rsp_q  <= rsp_d;
    end
  end

  // Per-port response steering; rdata is forced to 0 unless this port is
  // responding with a good read.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign rvalid[i] = rsp_q.vld & (rsp_q.port == 1'(i));
    assign err[i]    = rvalid[i] & rsp_q.err;
    assign rdata[i]  = (rvalid[i] & ~rsp_q.err) ? rom_rdata_i : '0;
  end

  assign p0_gnt_o    = gnt[0];
  assign p1_gnt_o    = gnt[1];
  assign p0_rvalid_o = rvalid[0];
  assign p1_rvalid_o = rvalid[1];
  assign p0_err_o    = err[0];
  assign p1_err_o    = err[1];
  assign p0_rdata_o  = rdata[0];
  assign p1_rdata_o  = rdata[1];

`ifdef BOOTROM_ARB_CNT_EN
  logic [31:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt[0] && cnt0_q != 32'hFFFF_FFFF) cnt0_d = cnt0_q + 32'd1;
    if (gnt[1] && cnt1_q != 32'hFFFF_FFFF) cnt1_d = cnt1_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign p0_cnt_o = cnt0_q;
  assign p1_cnt_o = cnt1_q;
`endif

endmodule

// File: tb/tb_bootrom_arbiter.sv
// tb_bootrom_arbiter
//   Directed and randomized bench for bootrom_arbiter. A transaction-level
//   model (priority bit plus one pending response) predicts grants, ROM
//   strobes and responses; the ROM is modelled as a function of address.
//   Counter checks are compiled in only when BOOTROM_ARB_CNT_EN is defined.
module tb_bootrom_arbiter;
  localparam int unsigned ROM_BYTES = 8192;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        p0_req_i, p1_req_i;
  logic [63:0] p0_addr_i, p1_addr_i;
  logic        p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, p0_err_o, p1_err_o;
  logic [63:0] p0_rdata_o, p1_rdata_o;
  logic        rom_req_o;
  logic [63:0] rom_addr_o;
  logic [63:0] rom_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
`ifdef BOOTROM_ARB_CNT_EN
  logic [31:0] p0_cnt_o, p1_cnt_o;
`endif

  bootrom_arbiter #(.ROM_BYTES(ROM_BYTES)) dut (
    .clk_i(clk_i), .rst(rst),
    .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i),
    .p1_req_i(p1_req_i), .p1_addr_i(p1_addr_i),
    .p0_gnt_o(p0_gnt_o), .p1_gnt_o(p1_gnt_o),
    .p0_rvalid_o(p0_rvalid_o), .p1_rvalid_o(p1_rvalid_o),
    .p0_rdata_o(p0_rdata_o), .p1_rdata_o(p1_rdata_o),
    .p0_err_o(p0_err_o), .p1_err_o(p1_err_o),
`ifdef BOOTROM_ARB_CNT_EN
    .p0_cnt_o(p0_cnt_o), .p1_cnt_o(p1_cnt_o),
`endif
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] romword(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  // ROM: one-cycle read; returns junk when not strobed so a missing rdata
  // mask is visible.
  always @(posedge clk_i)
    rom_rdata_i <= rom_req_o ? romword(rom_addr_o) : 64'hDEAD_BEEF_0000_0000 ^ 64'($urandom);

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_prio;            // port that wins a collision
  bit          p_vld;
  int          p_port;
  bit          p_err;
  logic [63:0] p_data;
  longint unsigned m_cnt [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check 1ns later, advance model to the edge.
  task automatic step(input logic r, input logic q0, input logic q1,
                      input logic [63:0] a0, input logic [63:0] a1);
    bit g0, g1, inr;
    logic [63:0] ga;
    @(negedge clk_i);
    rst = r; p0_req_i = q0; p1_req_i = q1; p0_addr_i = a0; p1_addr_i = a1;
    #1;
    if (r) begin
      p_vld = 0; m_prio = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    end
    g0 = 0; g1 = 0;
    if (!r) begin
      if (q0 && q1) begin g0 = (m_prio == 0); g1 = (m_prio == 1); end
      else begin g0 = q0; g1 = q1; end
    end
    ga  = g1 ? a1 : a0;
    inr = (g0 || g1) && (ga < 64'(ROM_BYTES));
    chk("p0_gnt", 64'(p0_gnt_o), 64'(g0));
    chk("p1_gnt", 64'(p1_gnt_o), 64'(g1));
    chk("rom_req", 64'(rom_req_o), 64'(inr));
    chk("rom_addr", rom_addr_o, inr ? ga : 64'h0);
    chk("p0_rvalid", 64'(p0_rvalid_o), 64'(p_vld && p_port == 0));
    chk("p1_rvalid", 64'(p1_rvalid_o), 64'(p_vld && p_port == 1));
    chk("p0_err", 64'(p0_err_o), 64'(p_vld && p_port == 0 && p_err));
    chk("p1_err", 64'(p1_err_o), 64'(p_vld && p_port == 1 && p_err));
    chk("p0_rdata", p0_rdata_o, (p_vld && p_port == 0) ? p_data : 64'h0);
    chk("p1_rdata", p1_rdata_o, (p_vld && p_port == 1) ? p_data : 64'h0);
`ifdef BOOTROM_ARB_CNT_EN
    chk("p0_cnt", 64'(p0_cnt_o), 64'(m_cnt[0]));
    chk("p1_cnt", 64'(p1_cnt_o), 64'(m_cnt[1]));
`endif
    // Advance to the next edge
    p_vld = g0 || g1;
    if (p_vld) begin
      p_port = g1 ? 1 : 0;
      p_err  = !inr;
      p_data = inr ? romword(ga) : 64'h0;
      m_prio = g1 ? 0 : 1;
      if (m_cnt[p_port] != 64'hFFFF_FFFF) m_cnt[p_port]++;
    end
    if (r) p_vld = 0;
  endtask

  function automatic logic [63:0] rnd_addr();
    case ($urandom_range(0, 5))
      0:       return 64'(ROM_BYTES - 1);
      1:       return 64'(ROM_BYTES);
      2:       return {$urandom, $urandom};
      default: return 64'($urandom_range(0, ROM_BYTES - 1));
    endcase
  endfunction

  initial begin
    rst = 1'b1; p0_req_i = 0; p1_req_i = 0; p0_addr_i = '0; p1_addr_i = '0;
    m_prio = 0; p_vld = 0; p_port = 0; p_err = 0; p_data = '0;
    m_cnt[0] = 0; m_cnt[1] = 0;

    // Reset state, requests ignored while in reset
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 64'h10, 64'h20);
    // Lone p0 read of 0x10, then idle to observe the response
    step(0, 1, 0, 64'h10, 64'h0);
    step(0, 0, 0, 64'h0, 64'h0);
    // Collision for 4 cycles: alternates starting from p1 (p0 just won)
    step(0, 1, 1, 64'h100, 64'h200);
    step(0, 1, 1, 64'h108, 64'h208);
    step(0, 1, 1, 64'h110, 64'h210);
    step(0, 1, 1, 64'h118, 64'h218);
    step(0, 0, 0, 0, 0);
    // Out-of-range on p1 and range boundary on p0
    step(0, 0, 1, 64'h0, 64'h2000);
    step(0, 1, 0, 64'h1FFF, 64'h0);
    step(0, 1, 0, 64'h2000, 64'h0);
    step(0, 0, 0, 0, 0);
    // Reset right after a p0 grant drops the response and restores priority
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 64'h40, 64'h0);
    step(1, 1, 1, 64'h48, 64'h50);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 64'h58, 64'h60);
    step(0, 0, 0, 0, 0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom), rnd_addr(), rnd_addr());
    step(0, 0, 0, 0, 0);

`ifdef BOOTROM_ARB_CNT_EN
    // Saturation: preload p0 counter near the top, then 3 more p0 grants
    @(negedge clk_i);
    force dut.cnt0_q = 32'hFFFF_FFFD;
    #1 release dut.cnt0_q;
    m_cnt[0] = 64'hFFFF_FFFD;
    step(0, 1, 0, 64'h8, 64'h0);
    step(0, 1, 0, 64'h8, 64'h0);
    step(0, 1, 0, 64'h8, 64'h0);
    step(0, 0, 0, 0, 0);
    chk("p0_cnt_sat", 64'(p0_cnt_o), 64'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bootrom_arbiter.md
BOOTROM_ARBITER -- requirements
Module: bootrom_arbiter

Interface
REQ-001 SHALL have parameter ROM_BYTES, default 8192, the byte size of the ROM window starting at address 0.
REQ-002 SHALL have clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst, input, 1, the reset: asynchronous and active-high.
REQ-004 SHALL have p0_req_i, p1_req_i, input, 1 each, the per-port read request.
REQ-005 SHALL have p0_addr_i, p1_addr_i, input, 64 each, the per-port byte address.
REQ-006 SHALL have p0_gnt_o, p1_gnt_o, output, 1 each, the per-port grant (combinational).
REQ-007 SHALL have p0_rvalid_o, p1_rvalid_o, output, 1 each, the per-port response valid (registered).
REQ-008 SHALL have p0_rdata_o, p1_rdata_o, output, 64 each, the per-port read data.
REQ-009 SHALL have p0_err_o, p1_err_o, output, 1 each, the per-port out-of-range flag, qualified by rvalid.
REQ-010 SHALL have rom_req_o, output, 1, the ROM access strobe.
REQ-011 SHALL have rom_addr_o, output, 64, the ROM address.
REQ-012 SHALL have rom_rdata_i, input, 64, the ROM data, valid exactly 1 cycle after rom_req_o.

Function
REQ-013 SHALL grant at most one port per cycle; gnt asserted only with the corresponding req.
REQ-014 SHALL use round-robin: with both reqs high, grant the priority port; after any grant, priority moves to the non-granted port.
REQ-015 SHALL grant a lone requester immediately regardless of priority, with zero added latency (gnt same cycle as req).
REQ-016 SHALL treat a grant as in-range when addr < ROM_BYTES; in-range grant drives rom_req_o=1 and rom_addr_o=granted addr in the same cycle.
REQ-017 SHALL, for an out-of-range grant, keep rom_req_o=0, then respond with rvalid=1, err=1, rdata=64'h0 one cycle later.
REQ-018 SHALL register {valid, port id, err} at grant; assert the granted port's rvalid exactly 1 cycle after gnt, for exactly 1 cycle.
REQ-019 SHALL drive the responding port's rdata from rom_rdata_i when err=0; rdata SHALL be 0 whenever rvalid=0.
REQ-020 SHALL support back-to-back grants every cycle (throughput 1 access/cycle); grant on cycle N+1 overlaps the response of cycle N.
REQ-021 SHALL drive rom_addr_o=0 when rom_req_o=0.
REQ-022 SHALL not depend on a requester holding req after gnt; a req dropped before gnt is simply not served.

Reset
REQ-023 SHALL, on rst=1 (asynchronous), clear the response register, set priority to port 0, and drive all rvalid, err and rdata outputs to 0.
REQ-024 SHALL, when reset is applied mid-operation, discard any outstanding response; no rvalid for a pre-reset grant appears after release.
REQ-025 SHALL force gnt=0 and rom_req_o=0 while rst=1.

Configuration
REQ-026 SHALL, with BOOTROM_ARB_CNT_EN defined, add outputs p0_cnt_o and p1_cnt_o (32 bits each), counting grants per port, saturating at 32'hFFFF_FFFF, reset to 0.
REQ-027 SHALL, without BOOTROM_ARB_CNT_EN, omit those ports and counters entirely, with otherwise identical behaviour.

Verification
REQ-028 Only p0 requests addr 0x10 after reset -> p0_gnt same cycle, rom_addr_o=0x10, p0_rvalid next cycle with rdata=ROM word, p1 outputs 0.
REQ-029 Both ports hold req for 4 cycles after reset -> grants p0,p1,p0,p1; each rvalid 1 cycle after its gnt.
REQ-030 p1 requests addr 0x2000 (ROM_BYTES=8192) -> p1_gnt=1, rom_req_o=0, next cycle p1_rvalid=1, p1_err=1, p1_rdata=0.
REQ-031 Grant p0 in cycle N, assert rst in cycle N+1 before the edge -> no p0_rvalid after release, priority back to p0.
REQ-032 With BOOTROM_ARB_CNT_EN, p0_cnt_o preloaded near 32'hFFFF_FFFF via forced state, then 3 more p0 grants -> p0_cnt_o stays 32'hFFFF_FFFF; without the macro, the ports are absent and the build still compiles.
